// File: rtl/uart_wb_host_pkg.sv
// -----------------------------------------------------------------------------
// uart_wb_host_pkg
//   Shared definitions for the UART Wishbone host: 16550 register offsets,
//   LSR/LCR bit positions and the sequencer state encoding.
// -----------------------------------------------------------------------------
package uart_wb_host_pkg;

  // 16550 register offsets. Several registers share an offset and are told
  // apart by direction (RBR/THR) or by LCR.DLAB (DLL/DLM vs RBR/IER).
  localparam int unsigned REG_RBR_THR = 0;
  localparam int unsigned REG_IER     = 1;
  localparam int unsigned REG_FCR     = 2;
  localparam int unsigned REG_LCR     = 3;
  localparam int unsigned REG_LSR     = 5;
  localparam int unsigned REG_DLL     = 0;
  localparam int unsigned REG_DLM     = 1;

  // Line status bits: receive data ready, transmit holding register empty.
  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_THRE = 5;

  // Divisor latch access bit in LCR.
  localparam int unsigned LCR_DLAB = 7;

  typedef enum logic [3:0] {
    INIT_LCR_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    INIT_IER,
    POLL,
    RD_RBR,
    WR_THR
  } state_e;

endpackage

// File: rtl/uart_wb_host_port.sv
// -----------------------------------------------------------------------------
// uart_wb_host_port
//   Single-access Wishbone classic initiator. A request seen while the bus is
//   idle launches one access; adr/dat/we are captured at that edge and held
//   until ack (or timeout). stb always drops for at least one cycle between
//   accesses because a new request is only taken while stb is low.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i               launch an access (ignored while one is in flight)
//   we_i, adr_i, wdat_i access attributes, sampled when stb rises
//   done_o              access acknowledged this cycle (combinational)
//   rdat_o              read data, valid with done_o
//   timeout_o           access abandoned this cycle after ACK_TIMEOUT cycles
//   wbm_*               Wishbone master signals (all driven from registers)
// -----------------------------------------------------------------------------
module uart_wb_host_port
  import uart_wb_host_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [7:0]            wdat_i,
  output logic                  done_o,
  output logic [7:0]            rdat_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [7:0]            wbm_dat_o,
  input  logic [7:0]            wbm_dat_i,
  output logic                  wbm_we_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_sel_o,
  input  logic                  wbm_ack_i
);

  // Counter holds the number of stb-high cycles already elapsed; the access
  // is abandoned in the stb cycle where it reaches ACK_TIMEOUT-1 without ack.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [7:0]            dat_q, dat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  expire;

  // An ack in the final allowed cycle still completes the access.
  assign expire    = (ACK_TIMEOUT > 0) && stb_q && !wbm_ack_i && (cnt_q == CNT_LAST);
  assign done_o    = stb_q && wbm_ack_i;
  assign rdat_o    = wbm_dat_i;
  assign timeout_o = expire;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (stb_q) begin
      if (wbm_ack_i || expire) begin
        stb_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (req_i) begin
      stb_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = wdat_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = stb_q;
  assign wbm_sel_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/uart_wb_host.sv
// -----------------------------------------------------------------------------
// uart_wb_host
//   Drives a 16550-compatible UART register file over Wishbone. After reset it
//   writes LCR(DLAB=1), DLL, DLM, LCR, FCR and IER, then polls LSR and moves
//   bytes between a TX valid/ready stream and THR, and between RBR and a
//   single-entry RX holding register.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbm_*                  Wishbone classic master to the UART
//   tx_data_i/tx_valid_i   byte to send; hold until tx_ready_o
//   tx_ready_o             one-cycle pulse after the THR write is acked
//   rx_data_o/rx_valid_o   received byte, held until rx_ready_i
//   init_done_o            register init sequence finished
//   timeout_err_o          sticky: some access was never acked in time
// -----------------------------------------------------------------------------
module uart_wb_host
  import uart_wb_host_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 3,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VALUE   = 8'h03,
  parameter logic [7:0]  FCR_VALUE   = 8'h07,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [7:0]            wbm_dat_o,
  input  logic [7:0]            wbm_dat_i,
  output logic                  wbm_we_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_sel_o,
  input  logic                  wbm_ack_i,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  init_done_o,
  output logic                  timeout_err_o
);

  state_e state_q, state_d;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [7:0]            wdat;
  logic                  done;
  logic                  timeout;
  logic [7:0]            rdat;

  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       tx_ready_q, tx_ready_d;
  logic       init_done_q, init_done_d;
  logic       timeout_err_q, timeout_err_d;

  uart_wb_host_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_port (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .req_i    (req),
    .we_i     (we),
    .adr_i    (adr),
    .wdat_i   (wdat),
    .done_o   (done),
    .rdat_o   (rdat),
    .timeout_o(timeout),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_we_o (wbm_we_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i)
  );

  // Every state names the access it wants; the port only acts on the request
  // while the bus is idle, so holding it through the access is harmless.
  always_comb begin
    state_d       = state_q;
    req           = 1'b1;
    we            = 1'b1;
    adr           = '0;
    wdat          = '0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready_i;
    tx_ready_d    = 1'b0;
    init_done_d   = init_done_q;
    timeout_err_d = timeout_err_q || timeout;

    unique case (state_q)
      INIT_LCR_DLAB: begin
        adr            = ADDR_WIDTH'(REG_LCR);
        wdat           = LCR_VALUE;
        wdat[LCR_DLAB] = 1'b1;
        if (done) state_d = INIT_DLL;
      end
      INIT_DLL: begin
        adr  = ADDR_WIDTH'(REG_DLL);
        wdat = DIVISOR[7:0];
        if (done) state_d = INIT_DLM;
      end
      INIT_DLM: begin
        adr  = ADDR_WIDTH'(REG_DLM);
        wdat = DIVISOR[15:8];
        if (done) state_d = INIT_LCR;
      end
      INIT_LCR: begin
        adr            = ADDR_WIDTH'(REG_LCR);
        wdat           = LCR_VALUE;
        wdat[LCR_DLAB] = 1'b0;
        if (done) state_d = INIT_FCR;
      end
      INIT_FCR: begin
        adr  = ADDR_WIDTH'(REG_FCR);
        wdat = FCR_VALUE;
        if (done) state_d = INIT_IER;
      end
      INIT_IER: begin
        adr  = ADDR_WIDTH'(REG_IER);
        wdat = 8'h00;
        if (done) begin
          state_d     = POLL;
          init_done_d = 1'b1;
        end
      end
      POLL: begin
        // Nothing useful can happen while the holding register is full and
        // no TX byte waits, so leave the bus quiet.
        req = !(rx_valid_q && !tx_valid_i);
        we  = 1'b0;
        adr = ADDR_WIDTH'(REG_LSR);
        if (done) begin
          if (rdat[LSR_DR] && !rx_valid_q) begin
            state_d = RD_RBR;
          end else if (rdat[LSR_THRE] && tx_valid_i) begin
            state_d = WR_THR;
          end
        end
      end
      RD_RBR: begin
        we  = 1'b0;
        adr = ADDR_WIDTH'(REG_RBR_THR);
        if (done) begin
          rx_data_d  = rdat;
          rx_valid_d = 1'b1;
          state_d    = POLL;
        end
      end
      WR_THR: begin
        adr  = ADDR_WIDTH'(REG_RBR_THR);
        wdat = tx_data_i;
        if (done) begin
          tx_ready_d = 1'b1;
          state_d    = POLL;
        end
      end
      default: state_d = INIT_LCR_DLAB;
    endcase

    // An abandoned access never produces a result; during init the UART state
    // is unknown, so the whole sequence starts over.
    if (timeout) begin
      state_d = init_done_q ? POLL : INIT_LCR_DLAB;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= INIT_LCR_DLAB;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      tx_ready_q    <= 1'b0;
      init_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      tx_ready_q    <= tx_ready_d;
      init_done_q   <= init_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign init_done_o   = init_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_wb_host.sv
// -----------------------------------------------------------------------------
// tb_uart_wb_host
//   Wishbone slave with two wait states standing in for the UART, a
//   transaction-level model of the host, a per-cycle compare process and a
//   directed test sequence with literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_wb_host;

  localparam int TO = 16;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } acc_t;

  localparam acc_t LSR_RD = '{we: 1'b0, adr: 3'd5, dat: 8'h00};
  localparam acc_t RBR_RD = '{we: 1'b0, adr: 3'd0, dat: 8'h00};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'h00;
  logic       we, stb, cyc, sel;
  logic       ack = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, init_done, timeout_err;

  always #5 clk = ~clk;

  uart_wb_host #(
    .ADDR_WIDTH (3),
    .DIVISOR    (16'd27),
    .LCR_VALUE  (8'h03),
    .FCR_VALUE  (8'h07),
    .ACK_TIMEOUT(TO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_we_o     (we),
    .wbm_stb_o    (stb),
    .wbm_cyc_o    (cyc),
    .wbm_sel_o    (sel),
    .wbm_ack_i    (ack),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .init_done_o  (init_done),
    .timeout_err_o(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave: acks after two wait states, returns LSR/RBR contents on reads.
  // ---------------------------------------------------------------------------
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  logic       no_ack  = 1'b0;
  int         wcnt    = 0;

  always @(negedge clk) begin
    if (ack) begin
      ack   = 1'b0;
      dat_i = 8'h00;
    end else if (stb && !rst && !no_ack) begin
      if (wcnt == 2) begin
        ack   = 1'b1;
        wcnt  = 0;
        dat_i = (adr == 3'd5) ? lsr_val : (adr == 3'd0) ? rbr_val : 8'h00;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Model + compare: state describes what the outputs must be in the next
  // cycle; accesses are predicted one transaction ahead.
  // ---------------------------------------------------------------------------
  acc_t init_seq [6] = '{
    '{we: 1'b1, adr: 3'd3, dat: 8'h83},
    '{we: 1'b1, adr: 3'd0, dat: 8'h1B},
    '{we: 1'b1, adr: 3'd1, dat: 8'h00},
    '{we: 1'b1, adr: 3'd3, dat: 8'h03},
    '{we: 1'b1, adr: 3'd2, dat: 8'h07},
    '{we: 1'b1, adr: 3'd1, dat: 8'h00}
  };

  int         m_idx  = 0;
  int         m_run  = 0;
  logic       m_done = 1'b0, m_rxv = 1'b0, m_txr = 1'b0, m_to = 1'b0;
  logic       m_low = 1'b0, m_hold = 1'b0, m_stall = 1'b0, m_prst = 1'b0;
  logic [7:0] m_rxd  = 8'h00;
  acc_t       m_next = LSR_RD;
  acc_t       m_hacc = '0;

  int   n_acks = 0, n_rbr = 0, n_txr = 0;
  acc_t last_acc = '0;

  initial begin : compare
    acc_t cur, exp;
    logic nxt_rxv;
    forever begin
      @(negedge clk);
      #1;
      cur = '{we: we, adr: adr, dat: dat_o};

      check("cyc_eq_stb", cyc, stb);
      check("sel_eq_stb", sel, stb);
      check("init_done", init_done, m_done);
      check("rx_valid", rx_valid, m_rxv);
      check("tx_ready", tx_ready, m_txr);
      check("timeout_err", timeout_err, m_to);
      if (m_rxv) check("rx_data", rx_data, m_rxd);
      if (m_prst) begin
        check("rst_stb", stb, 0);
        check("rst_adr", adr, 0);
        check("rst_dat", dat_o, 0);
        check("rst_we", we, 0);
        check("rst_rx_data", rx_data, 0);
      end
      if (m_low) check("stb_gap", stb, 0);
      if (m_stall) check("stall_no_access", stb, 0);
      if (m_hold) begin
        check("stb_hold", stb, 1);
        check("acc_stable", cur, m_hacc);
      end
      if (tx_ready) n_txr++;

      m_prst  = rst;
      m_low   = 1'b0;
      m_hold  = 1'b0;
      m_txr   = 1'b0;
      m_stall = 1'b0;
      if (rst) begin
        m_idx  = 0;
        m_run  = 0;
        m_done = 1'b0;
        m_rxv  = 1'b0;
        m_rxd  = 8'h00;
        m_to   = 1'b0;
        m_next = LSR_RD;
      end else begin
        nxt_rxv = m_rxv && !rx_ready;
        m_stall = m_done && !stb && m_rxv && !tx_valid && (m_next == LSR_RD);
        if (stb) begin
          m_run++;
          if (ack) begin
            n_acks++;
            last_acc = cur;
            exp = (m_idx < 6) ? init_seq[m_idx] : m_next;
            check("acc_we", cur.we, exp.we);
            check("acc_adr", cur.adr, exp.adr);
            if (exp.we) check("acc_dat", cur.dat, exp.dat);
            if (m_idx < 6) begin
              m_idx++;
              if (m_idx == 6) begin
                m_done = 1'b1;
                m_next = LSR_RD;
              end
            end else if (m_next == LSR_RD) begin
              if (dat_i[0] && !m_rxv) m_next = RBR_RD;
              else if (dat_i[5] && tx_valid) m_next = '{we: 1'b1, adr: 3'd0, dat: tx_data};
            end else if (m_next == RBR_RD) begin
              m_rxd   = dat_i;
              nxt_rxv = 1'b1;
              n_rbr++;
              m_next  = LSR_RD;
            end else begin
              m_txr  = 1'b1;
              m_next = LSR_RD;
            end
            m_low = 1'b1;
            m_run = 0;
          end else if (m_run == TO) begin
            m_to  = 1'b1;
            m_low = 1'b1;
            m_run = 0;
            if (m_idx < 6) m_idx = 0;
            else m_next = LSR_RD;
          end else begin
            m_hold = 1'b1;
            m_hacc = cur;
          end
        end else begin
          m_run = 0;
        end
        m_rxv = nxt_rxv;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 300 && !init_done; i++) tick();
    check(name, init_done, 1);
  endtask

  task automatic wait_tx_ready(input string name);
    for (int i = 0; i < 100 && !tx_ready; i++) tick();
    check(name, tx_ready, 1);
  endtask

  initial begin : stimulus
    int n0, hi;
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Init: six writes, nothing else before init_done.
    wait_init("init_done_rise");
    check("init_write_count", n_acks, 6);
    check("init_last_write", last_acc, {1'b1, 3'd1, 8'h00});

    // TX only.
    n0       = n_txr;
    lsr_val  = 8'h20;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_tx_ready("tx_ready_a5");
    check("thr_write_a5", last_acc, {1'b1, 3'd0, 8'hA5});
    tx_valid = 1'b0;
    lsr_val  = 8'h00;
    repeat (10) tick();
    check("tx_ready_one_pulse", n_txr - n0, 1);

    // RX has priority over a pending TX byte; holding register stays full.
    n0       = n_rbr;
    lsr_val  = 8'h21;
    rbr_val  = 8'h3C;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wait_tx_ready("tx_ready_5a");
    check("thr_write_5a", last_acc, {1'b1, 3'd0, 8'h5A});
    check("rx_valid_set", rx_valid, 1);
    check("rx_data_3c", rx_data, 8'h3C);
    check("rbr_read_once", n_rbr - n0, 1);
    tx_valid = 1'b0;
    repeat (12) tick();
    check("rbr_not_reread", n_rbr - n0, 1);
    check("rx_valid_held", rx_valid, 1);
    lsr_val  = 8'h00;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    check("rx_valid_cleared", rx_valid, 0);

    // Reset in the middle of a THR write.
    lsr_val  = 8'h20;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !(stb && we); i++) tick();
    check("thr_in_flight", stb && we, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_stb", stb, 0);
    check("rst_mid_cyc", cyc, 0);
    check("rst_mid_tx_ready", tx_ready, 0);
    check("rst_mid_rx_valid", rx_valid, 0);
    check("rst_mid_init_done", init_done, 0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    lsr_val  = 8'h00;
    n0       = n_acks;
    for (int i = 0; i < 50 && n_acks == n0; i++) tick();
    check("restart_first_write", last_acc, {1'b1, 3'd3, 8'h83});
    wait_init("init_done_after_rst");

    // Ack timeout on the first LCR write.
    no_ack = 1'b1;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50 && !stb; i++) tick();
    check("to_stb_rise", stb, 1);
    hi = 0;
    for (int i = 0; i < 40 && stb; i++) begin
      hi++;
      tick();
    end
    check("to_stb_cycles", hi, TO);
    check("to_err_set", timeout_err, 1);
    no_ack = 1'b0;
    n0     = n_acks;
    for (int i = 0; i < 50 && n_acks == n0; i++) tick();
    check("to_restart_write", last_acc, {1'b1, 3'd3, 8'h83});
    wait_init("init_done_after_to");
    check("to_err_sticky", timeout_err, 1);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
